// File: rtl/pipe_mux.sv
// pipe_mux: N-way channel select feeding a 2-entry skid buffer with registered in_ready.
// An out-of-range select yields an all-zero word and sets a sticky sel_err flag.
module pipe_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               flush,
  output logic               sel_err
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_m, r_s, w_word;
  logic             r_ready, r_err, w_acc, w_con, w_oor, w_ld_m, w_ld_s, w_pro;
  assign in_ready  = r_ready;
  assign sel_err   = r_err;
  assign out_data  = r_m;
  assign out_valid = r_state != EMPTY;
  assign w_acc     = in_valid && r_ready;
  assign w_con     = out_valid && out_ready;
  assign w_oor     = 32'(sel) >= N;
  always_comb begin
    w_word = '0;
    for (int k = 0; k < N; k++)
      if (32'(sel) == k) w_word = in_data[k*WIDTH +: WIDTH];
  end
  always_comb begin
    w_next = r_state;
    w_ld_m = 1'b0;
    w_ld_s = 1'b0;
    w_pro  = 1'b0;
    case (r_state)
      EMPTY: if (w_acc) begin
        w_next = ONE;
        w_ld_m = 1'b1;
      end
      ONE: if (w_acc && w_con) w_ld_m = 1'b1;
        else if (w_acc) begin
          w_next = TWO;
          w_ld_s = 1'b1;
        end else if (w_con) w_next = EMPTY;
      TWO: if (w_con) begin
        w_next = ONE;
        w_pro  = 1'b1;
      end
      default: w_next = EMPTY;
    endcase
    // flush wins over any same-cycle accept or consume; nothing is loaded
    if (flush) begin
      w_next = EMPTY;
      w_ld_m = 1'b0;
      w_ld_s = 1'b0;
      w_pro  = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= EMPTY;
      r_m     <= '0;
      r_s     <= '0;
      r_ready <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= w_next != TWO;
      r_err   <= r_err || (w_acc && w_oor);
      if (w_ld_m) r_m <= w_word;
      else if (w_pro) r_m <= r_s;
      if (w_ld_s) r_s <= w_word;
    end
  end
endmodule

// File: tb/tb_pipe_mux.sv
// tb_pipe_mux: directed scenario tasks plus a random run against a queue model.
// A second instance with N=3 covers out-of-range selects.
module tb_pipe_mux;
  logic         clk = 1'b0;
  logic         reset = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [1:0]   sel = '0;
  logic [127:0] in_data = '0;
  logic [31:0]  d4_data, d3_data;
  logic         d4_valid, d4_ready, d4_err, d3_valid, d3_ready, d3_err;
  int           tests = 0, fails = 0;

  always #5 clk = ~clk;

  pipe_mux #(.WIDTH(32), .N(4), .SELW(2)) u_d4 (
    .clk(clk), .reset(reset), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .in_ready(d4_ready), .out_data(d4_data), .out_valid(d4_valid),
    .out_ready(out_ready), .flush(flush), .sel_err(d4_err));

  pipe_mux #(.WIDTH(32), .N(3), .SELW(2)) u_d3 (
    .clk(clk), .reset(reset), .in_data(in_data[95:0]), .sel(sel), .in_valid(in_valid),
    .in_ready(d3_ready), .out_data(d3_data), .out_valid(d3_valid),
    .out_ready(out_ready), .flush(flush), .sel_err(d3_err));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; out_ready = 0; flush = 0; sel = 0; in_data = '0;
    reset = 1;
    cyc();
    reset = 0;
  endtask

  task automatic test_reset();
    in_valid = 0; out_ready = 0; flush = 0;
    reset = 1;
    #3;
    tests++; if (d4_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", d4_valid); end
    tests++; if (d4_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", d4_ready); end
    tests++; if (d4_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", d4_err); end
    tests++; if (d4_data !== 32'h0) begin fails++; $display("FAIL reset_data got %h want 0", d4_data); end
    cyc();
    reset = 0;
  endtask

  task automatic test_basic();
    do_reset();
    in_data = {32'h33333333, 32'hDEADBEEF, 32'h11111111, 32'h00000000};
    sel = 2; in_valid = 1; out_ready = 1;
    cyc();
    in_valid = 0;
    tests++; if (d4_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %b want 1", d4_valid); end
    tests++; if (d4_data !== 32'hDEADBEEF) begin fails++; $display("FAIL basic_data got %h want deadbeef", d4_data); end
    tests++; if (d4_ready !== 1'b1) begin fails++; $display("FAIL basic_ready got %b want 1", d4_ready); end
    cyc();
    tests++; if (d4_valid !== 1'b0) begin fails++; $display("FAIL basic_empty got %b want 0", d4_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 0; sel = 0; in_data = 128'h11; in_valid = 1;
    cyc();
    tests++; if (d4_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_one got %b want 1", d4_ready); end
    in_data = 128'h22;
    cyc();
    in_valid = 0;
    tests++; if (d4_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_two got %b want 0", d4_ready); end
    tests++; if (d4_data !== 32'h11) begin fails++; $display("FAIL bp_head got %h want 11", d4_data); end
    cyc();
    tests++; if (d4_data !== 32'h11) begin fails++; $display("FAIL bp_stall got %h want 11", d4_data); end
    out_ready = 1;
    cyc();
    tests++; if (d4_data !== 32'h22 || d4_valid !== 1'b1) begin fails++; $display("FAIL bp_second got %h/%b want 22/1", d4_data, d4_valid); end
    tests++; if (d4_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_back got %b want 1", d4_ready); end
    cyc();
    tests++; if (d4_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got %b want 0", d4_valid); end
  endtask

  task automatic test_sel_err();
    do_reset();
    in_data = {32'hCCCC0003, 32'hCCCC0002, 32'hCCCC0001, 32'hCCCC0000};
    sel = 3; in_valid = 1; out_ready = 1;
    cyc();
    tests++; if (d3_data !== 32'h0 || d3_valid !== 1'b1) begin fails++; $display("FAIL oor_data got %h/%b want 0/1", d3_data, d3_valid); end
    tests++; if (d3_err !== 1'b1) begin fails++; $display("FAIL oor_err got %b want 1", d3_err); end
    tests++; if (d4_data !== 32'hCCCC0003 || d4_err !== 1'b0) begin fails++; $display("FAIL inrange_sel3 got %h/%b want cccc0003/0", d4_data, d4_err); end
    sel = 1;
    cyc();
    in_valid = 0;
    tests++; if (d3_data !== 32'hCCCC0001) begin fails++; $display("FAIL oor_next_data got %h want cccc0001", d3_data); end
    cyc();
    tests++; if (d3_err !== 1'b1 || d3_valid !== 1'b0) begin fails++; $display("FAIL oor_sticky got %b/%b want 1/0", d3_err, d3_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 0; sel = 0; in_data = 128'h33; in_valid = 1;
    cyc();
    in_data = 128'h44;
    cyc();
    tests++; if (d4_ready !== 1'b0) begin fails++; $display("FAIL flush_pre_two got %b want 0", d4_ready); end
    in_data = 128'h55; flush = 1;
    cyc();
    flush = 0; in_valid = 0;
    tests++; if (d4_valid !== 1'b0 || d4_ready !== 1'b1) begin fails++; $display("FAIL flush_state got %b/%b want 0/1", d4_valid, d4_ready); end
    in_data = 128'h66; in_valid = 1; out_ready = 1;
    cyc();
    in_valid = 0;
    tests++; if (d4_data !== 32'h66 || d4_valid !== 1'b1) begin fails++; $display("FAIL flush_after got %h/%b want 66/1", d4_data, d4_valid); end
    cyc();
    tests++; if (d4_valid !== 1'b0) begin fails++; $display("FAIL flush_stale got %b want 0", d4_valid); end
    do_reset();
    sel = 3; in_valid = 1; flush = 1;
    cyc();
    in_valid = 0; flush = 0;
    tests++; if (d3_err !== 1'b1 || d3_valid !== 1'b0) begin fails++; $display("FAIL flush_oor got %b/%b want 1/0", d3_err, d3_valid); end
  endtask

  task automatic test_async_reset();
    do_reset();
    sel = 0; in_data = 128'h77; in_valid = 1;
    cyc();
    in_valid = 0;
    tests++; if (d4_valid !== 1'b1) begin fails++; $display("FAIL ar_one got %b want 1", d4_valid); end
    #2 reset = 1;
    #1;
    tests++; if (d4_valid !== 1'b0 || d4_data !== 32'h0) begin fails++; $display("FAIL ar_drop got %b/%h want 0/0", d4_valid, d4_data); end
    reset = 0;
    in_data = 128'hA5; in_valid = 1; out_ready = 1;
    cyc();
    in_valid = 0;
    tests++; if (d4_data !== 32'hA5 || d4_valid !== 1'b1) begin fails++; $display("FAIL ar_a5 got %h/%b want a5/1", d4_data, d4_valid); end
    cyc();
    tests++; if (d4_valid !== 1'b0) begin fails++; $display("FAIL ar_single got %b want 0", d4_valid); end
  endtask

  task automatic test_stress();
    logic [31:0] q[$];
    logic [31:0] ch[4];
    int          errs = 0;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      tests++;
      if (d4_ready !== (q.size() < 2) || d4_valid !== (q.size() > 0) ||
          (q.size() > 0 && d4_data !== q[0])) begin
        fails++; errs++;
        if (errs < 10) $display("FAIL stress cycle %0d got rdy=%b vld=%b data=%h want rdy=%b vld=%b data=%h",
          c, d4_ready, d4_valid, d4_data, q.size() < 2, q.size() > 0, q.size() > 0 ? q[0] : 32'h0);
      end
      for (int k = 0; k < 4; k++) ch[k] = $urandom;
      in_data = {ch[3], ch[2], ch[1], ch[0]};
      sel = 2'($urandom_range(0, 3));
      in_valid = 1'($urandom);
      out_ready = 1'($urandom);
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (in_valid && q.size() + (q.size() > 0 && out_ready ? 1 : 0) < 2) q.push_back(ch[sel]);
      cyc();
    end
    in_valid = 0;
    tests++; if (d4_err !== 1'b0) begin fails++; $display("FAIL stress_err got %b want 0", d4_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_sel_err();
    test_flush();
    test_async_reset();
    test_stress();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
